filter_test_harness: RTL and testbench

FILTER_TEST_HARNESS -- requirements
Module: filter_test_harness

---
 rtl/filter_harness_pkg.sv | 20 ++
 rtl/harness_sink.sv | 25 ++
 rtl/filter_test_harness.sv | 130 +++++++++++++
 tb/tb_filter_test_harness.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_harness_pkg.sv
// Shared definitions for the filter test harness: sample width, FSM state
// encoding and the default biquad coefficients (a lowpass section).
package filter_harness_pkg;

  localparam int NB = 12;

  localparam int DEF_B0 = 205;
  localparam int DEF_B1 = 410;
  localparam int DEF_B2 = 205;
  localparam int DEF_A1 = -1300;
  localparam int DEF_A2 = 500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/harness_sink.sv
// Response sink: counts accepted filter outputs and keeps a running 16-bit
// checksum of them. Accepts on every vIn cycle regardless of harness state.
module harness_sink #(
  parameter int NB = filter_harness_pkg::NB
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vIn,
  input  logic [NB-1:0] dIn,
  output logic [15:0]   rx_count,
  output logic [15:0]   rx_checksum
);

  // Accumulate count and zero-extended sum of accepted samples, both mod 2^16.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_count    <= '0;
      rx_checksum <= '0;
    end else if (vIn) begin
      rx_count    <= rx_count + 16'd1;
      rx_checksum <= rx_checksum + 16'(dIn);
    end
  end

endmodule

// File: rtl/filter_test_harness.sv
// Stimulus/response harness for a filter under test. Sends a sawtooth of
// NUM_SAMPLES samples after START_DELAY idle cycles, waits DRAIN_CYCLES,
// then raises a sticky end_sim. Optional macro VIN_GAP_EN drops vOut on
// every 4th SEND cycle (sample index held) to exercise a gapped stream.
//
// state | meaning
// IDLE  | post-reset delay of START_DELAY cycles
// SEND  | one sawtooth sample per cycle on vOut/dOut
// DRAIN | DRAIN_CYCLES cycles waiting for filter latency to flush
// DONE  | end_sim held high until reset
module filter_test_harness #(
  parameter int NB           = filter_harness_pkg::NB,
  parameter int NUM_SAMPLES  = 64,
  parameter int STEP         = 64,
  parameter int START_DELAY  = 4,
  parameter int DRAIN_CYCLES = 16,
  parameter logic signed [NB-1:0] B0 = NB'(filter_harness_pkg::DEF_B0),
  parameter logic signed [NB-1:0] B1 = NB'(filter_harness_pkg::DEF_B1),
  parameter logic signed [NB-1:0] B2 = NB'(filter_harness_pkg::DEF_B2),
  parameter logic signed [NB-1:0] A1 = NB'(filter_harness_pkg::DEF_A1),
  parameter logic signed [NB-1:0] A2 = NB'(filter_harness_pkg::DEF_A2)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            vOut,
  output logic [NB-1:0]   dOut,
  output logic [3*NB-1:0] b,
  output logic [2*NB-1:0] a,
  input  logic            vIn,
  input  logic [NB-1:0]   dIn,
  output logic            end_sim,
  output logic [15:0]     rx_count,
  output logic [15:0]     rx_checksum
);

  import filter_harness_pkg::*;

  localparam logic [NB-1:0] STEP_NB    = NB'(STEP);
  localparam logic [15:0]   DELAY_LAST = 16'(START_DELAY - 1);
  localparam logic [15:0]   NUM_LAST   = 16'(NUM_SAMPLES);
  localparam logic [15:0]   DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [15:0] delay_cnt;
  logic [15:0] sent_cnt;
  logic [15:0] drain_cnt;
`ifdef VIN_GAP_EN
  logic [1:0]  gap_phase;
`endif

  // Coefficients are static wiring, independent of reset and state.
  assign b = {B2, B1, B0};
  assign a = {A2, A1};

  // Sequencer: delay, sawtooth send, drain down-count, sticky done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      delay_cnt <= '0;
      sent_cnt  <= '0;
      drain_cnt <= '0;
      vOut      <= 1'b0;
      dOut      <= '0;
      end_sim   <= 1'b0;
`ifdef VIN_GAP_EN
      gap_phase <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (delay_cnt == DELAY_LAST) begin
            state    <= SEND;
            vOut     <= 1'b1;
            dOut     <= '0;
            sent_cnt <= 16'd1;
`ifdef VIN_GAP_EN
            gap_phase <= '0;
`endif
          end else begin
            delay_cnt <= delay_cnt + 16'd1;
          end
        end
        SEND: begin
          if (sent_cnt == NUM_LAST) begin
            // dOut deliberately keeps the last sample through DRAIN/DONE
            state     <= DRAIN;
            vOut      <= 1'b0;
            drain_cnt <= DRAIN_LAST;
`ifdef VIN_GAP_EN
          end else if (gap_phase == 2'd2) begin
            vOut      <= 1'b0;
            gap_phase <= gap_phase + 2'd1;
`endif
          end else begin
            vOut     <= 1'b1;
            dOut     <= dOut + STEP_NB;
            sent_cnt <= sent_cnt + 16'd1;
`ifdef VIN_GAP_EN
            gap_phase <= gap_phase + 2'd1;
`endif
          end
        end
        DRAIN: begin
          if (drain_cnt == 16'd0) begin
            state   <= DONE;
            end_sim <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 16'd1;
          end
        end
        DONE: begin
          end_sim <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  harness_sink #(
    .NB(NB)
  ) u_sink (
    .clock       (clock),
    .reset       (reset),
    .vIn         (vIn),
    .dIn         (dIn),
    .rx_count    (rx_count),
    .rx_checksum (rx_checksum)
  );

endmodule

// File: tb/tb_filter_test_harness.sv
// Directed bench for filter_test_harness: reset values, start latency,
// sawtooth sequences, wrap, sink accounting, drain length, mid-run reset,
// and (with VIN_GAP_EN) the gapped send pattern.
module tb_filter_test_harness;

  localparam int NB = 12;

  logic clock;
  logic reset;
  logic vIn;
  logic [NB-1:0] dIn;

  logic            v0, v8, vw, vg;
  logic [NB-1:0]   d0, d8, dw, dg;
  logic [3*NB-1:0] b0, b8, bw, bg;
  logic [2*NB-1:0] a0, a8, aw, ag;
  logic            e0, e8, ew, eg;
  logic [15:0]     c0, c8, cw, cg;
  logic [15:0]     s0, s8, sw, sg;

  int checks = 0;
  int passes = 0;

  filter_test_harness dut (
    .clock(clock), .reset(reset), .vOut(v0), .dOut(d0), .b(b0), .a(a0),
    .vIn(vIn), .dIn(dIn), .end_sim(e0), .rx_count(c0), .rx_checksum(s0)
  );

  filter_test_harness #(.NUM_SAMPLES(8), .STEP(64)) dut8 (
    .clock(clock), .reset(reset), .vOut(v8), .dOut(d8), .b(b8), .a(a8),
    .vIn(vIn), .dIn(dIn), .end_sim(e8), .rx_count(c8), .rx_checksum(s8)
  );

  filter_test_harness #(.NUM_SAMPLES(5), .STEP(1024)) dut_wrap (
    .clock(clock), .reset(reset), .vOut(vw), .dOut(dw), .b(bw), .a(aw),
    .vIn(vIn), .dIn(dIn), .end_sim(ew), .rx_count(cw), .rx_checksum(sw)
  );

  filter_test_harness #(.NUM_SAMPLES(6), .STEP(1)) dut_gap (
    .clock(clock), .reset(reset), .vOut(vg), .dOut(dg), .b(bg), .a(ag),
    .vIn(vIn), .dIn(dIn), .end_sim(eg), .rx_count(cg), .rx_checksum(sg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first SEND cycle.
  task automatic wait_send_entry();
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vIn   = 1'b0;
    dIn   = '0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({v0, d0, e0, c0, s0} !== '0)
        $display("FAIL reset_outputs: vOut=%0b dOut=%0d end_sim=%0b rx_count=%0d rx_checksum=%0d, required all 0",
                 v0, d0, e0, c0, s0);
      else passes++;
    end
    checks++;
    if (b0 !== {12'd205, 12'd410, 12'd205})
      $display("FAIL coef_b: got %h, required %h", b0, {12'd205, 12'd410, 12'd205});
    else passes++;
    checks++;
    if (a0 !== {12'h1F4, 12'hAEC})
      $display("FAIL coef_a: got %h, required %h", a0, {12'h1F4, 12'hAEC});
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_start_latency();
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (i < 4) begin
        if (v0 !== 1'b0) $display("FAIL start_idle: edge %0d vOut=%0b, required 0", i, v0);
        else passes++;
      end else begin
        if (v0 !== 1'b1 || d0 !== 12'd0)
          $display("FAIL start_first: vOut=%0b dOut=%0d, required vOut=1 dOut=0", v0, d0);
        else passes++;
      end
    end
  endtask

  task automatic test_sink();
    apply_reset();
    vIn = 1'b1; dIn = 12'd100;
    @(negedge clock);
    checks++;
    if (c0 !== 16'd1 || s0 !== 16'd100)
      $display("FAIL sink_first: count=%0d sum=%0d, required 1/100", c0, s0);
    else passes++;
    vIn = 1'b1; dIn = 12'd200;
    @(negedge clock);
    vIn = 1'b0; dIn = 12'd999;
    @(negedge clock);
    checks++;
    if (c0 !== 16'd2 || s0 !== 16'd300)
      $display("FAIL sink_ignore: count=%0d sum=%0d, required 2/300", c0, s0);
    else passes++;
    vIn = 1'b1; dIn = 12'd300;
    @(negedge clock);
    vIn = 1'b0; dIn = '0;
    @(negedge clock);
    checks++;
    if (c0 !== 16'd3 || s0 !== 16'd600)
      $display("FAIL sink_total: count=%0d sum=%0d, required 3/600", c0, s0);
    else passes++;
  endtask

`ifndef VIN_GAP_EN
  task automatic test_sawtooth();
    int exp_w[5] = '{0, 1024, 2048, 3072, 0};
    apply_reset();
    wait_send_entry();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (v8 !== 1'b1 || d8 !== 12'(k * 64))
        $display("FAIL saw8_k%0d: vOut=%0b dOut=%0d, required 1/%0d", k, v8, d8, k * 64);
      else passes++;
      if (k < 5) begin
        checks++;
        if (vw !== 1'b1 || dw !== 12'(exp_w[k]))
          $display("FAIL wrap_k%0d: vOut=%0b dOut=%0d, required 1/%0d", k, vw, dw, exp_w[k]);
        else passes++;
      end else if (k == 5) begin
        checks++;
        if (vw !== 1'b0 || dw !== 12'd0)
          $display("FAIL wrap_end: vOut=%0b dOut=%0d, required 0/0", vw, dw);
        else passes++;
      end
      @(negedge clock);
    end
    checks++;
    if (v8 !== 1'b0 || d8 !== 12'd448)
      $display("FAIL saw8_end: vOut=%0b dOut=%0d, required 0/448", v8, d8);
    else passes++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    wait_send_entry();
    vIn = 1'b1; dIn = 12'd4095;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (v0 !== 1'b1 || d0 !== 12'(k * 64))
        $display("FAIL b2b_send_k%0d: vOut=%0b dOut=%0d, required 1/%0d", k, v0, d0, k * 64);
      else passes++;
      @(negedge clock);
    end
    vIn = 1'b0; dIn = '0;
    @(negedge clock);
    checks++;
    if (c0 !== 16'd20 || s0 !== 16'd16364)
      $display("FAIL b2b_sink: count=%0d sum=%0d, required 20/16364", c0, s0);
    else passes++;
  endtask

  task automatic test_end_sim();
    int ones;
    int lows;
    bit seen;
    bit held;
    apply_reset();
    ones = 0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (v0) begin ones++; seen = 1'b1; end
      else if (seen) break;
    end
    checks++;
    if (ones !== 64 || v0 !== 1'b0)
      $display("FAIL send_count: vOut high %0d cycles, required 64 then low", ones);
    else passes++;
    checks++;
    if (d0 !== 12'd4032)
      $display("FAIL drain_hold: dOut=%0d, required 4032", d0);
    else passes++;
    lows = 0;
    while (e0 !== 1'b1 && lows < 100) begin
      lows++;
      @(negedge clock);
    end
    checks++;
    if (lows !== 16)
      $display("FAIL drain_len: end_sim low %0d cycles after last sample, required 16", lows);
    else passes++;
    held = 1'b1;
    vIn = 1'b1; dIn = 12'd50;
    @(negedge clock);
    vIn = 1'b0; dIn = '0;
    repeat (20) begin
      @(negedge clock);
      if (e0 !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) $display("FAIL end_sticky: end_sim dropped, required to stay 1");
    else passes++;
    checks++;
    if (c0 !== 16'd1 || s0 !== 16'd50)
      $display("FAIL sink_done: count=%0d sum=%0d, required 1/50", c0, s0);
    else passes++;
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (e0 !== 1'b0 || c0 !== 16'd0 || s0 !== 16'd0)
      $display("FAIL reset_done: end_sim=%0b count=%0d sum=%0d, required 0/0/0", e0, c0, s0);
    else passes++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_send_entry();
    repeat (10) @(negedge clock);
    checks++;
    if (d0 !== 12'd640) $display("FAIL pre_abort: dOut=%0d, required 640", d0);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (v0 !== 1'b0 || d0 !== 12'd0)
      $display("FAIL abort_send: vOut=%0b dOut=%0d, required 0/0", v0, d0);
    else passes++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_send_entry();
    checks++;
    if (v0 !== 1'b1 || d0 !== 12'd0)
      $display("FAIL restart_k0: vOut=%0b dOut=%0d, required 1/0", v0, d0);
    else passes++;
    @(negedge clock);
    checks++;
    if (v0 !== 1'b1 || d0 !== 12'd64)
      $display("FAIL restart_k1: vOut=%0b dOut=%0d, required 1/64", v0, d0);
    else passes++;
  endtask
`else
  task automatic test_gap();
    logic       exp_v[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] exp_d[8] = '{12'd0, 12'd1, 12'd2, 12'd2, 12'd3, 12'd4, 12'd5, 12'd5};
    apply_reset();
    wait_send_entry();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (vg !== exp_v[k] || dg !== exp_d[k])
        $display("FAIL gap_c%0d: vOut=%0b dOut=%0d, required %0b/%0d", k, vg, dg, exp_v[k], exp_d[k]);
      else passes++;
      @(negedge clock);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_latency();
    test_sink();
`ifndef VIN_GAP_EN
    test_sawtooth();
    test_back_to_back();
    test_end_sim();
    test_mid_reset();
`else
    test_gap();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
